led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
Controller that plays an LED animation stored in a single-port pattern BRAM. It steps an address pointer through the memory, holds each pattern on the LEDs for a programmable number of clock ticks, and optionally loops. It also arbitrates the one BRAM port between its own playback reads and a loader write port (future UART loader). It sits between the slow clock from the clock divider and the board LEDs, replacing the free-running PC counter.

Parameters:
ADDR_W, 5, pattern memory address width
DATA_W, 5, pattern word / LED width
DEPTH, 21, number of valid pattern words (addresses 0..DEPTH-1)
HOLD_W, 16, width of hold-count input

Ports:
clk  in  1  system clock (slow clock from the clock divider)
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin playback from address 0
stop  in  1  one-cycle request to abort playback
pause  in  1  level; freezes hold countdown while high
loop_en  in  1  level; restart at 0 after last_addr instead of finishing
last_addr  in  ADDR_W  final step address, sampled on accepted start
hold_cycles  in  HOLD_W  ticks per step, sampled on entry to HOLD
mem_addr  out  ADDR_W  BRAM address (shared read/write)
mem_rd_en  out  1  BRAM read enable
mem_we  out  1  BRAM write enable
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data, valid 1 cycle after mem_rd_en
wr_req  in  1  loader write request (level, held until ack)
wr_addr  in  ADDR_W  loader write address
wr_data  in  DATA_W  loader write data
wr_ack  out  1  combinational grant; write performed this cycle
led  out  DATA_W  current pattern
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at non-looping end of playback
step_addr  out  ADDR_W  address of pattern currently shown

Behaviour:
- Reset (async, rst=1): state IDLE, pointer 0, led 0, step_addr 0, busy 0, done 0, mem_rd_en 0, mem_we 0.
- States: IDLE, FETCH, WAIT, HOLD, DONE.
- IDLE: start=1 -> FETCH, pointer 0, latch last_addr (clamped to DEPTH-1 if larger). start while busy ignored.
- FETCH: mem_rd_en=1, mem_addr=pointer; -> WAIT.
- WAIT: mem_rdata valid; led <= mem_rdata, step_addr <= pointer at end of cycle; counter <= max(hold_cycles,1)-1; -> HOLD.
- HOLD: counter decrements each cycle pause=0; at counter 0 with pause=0: pointer==last -> (loop_en ? pointer 0, FETCH : DONE); else pointer+1, FETCH.
- Step period = max(hold_cycles,1)+2 cycles; led changes 3 cycles after start is sampled (FETCH, WAIT, update).
- DONE: done=1 for exactly this cycle; -> IDLE. led keeps last pattern.
- stop=1 in any non-IDLE state: -> IDLE next edge, pointer 0, led unchanged, no done pulse. stop beats start in the same cycle.
- pause in FETCH/WAIT: the fetch completes, then the block freezes in HOLD with the counter loaded.
- Arbitration: wr_ack = wr_req && state!=FETCH. When granted: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data. Reads always win, so a write is delayed at most one cycle. Writes do not change led; a write to the address being shown takes effect on the next fetch of that address.
- Pointer arithmetic is modulo-free: the pointer never exceeds the latched last_addr.

Decomposition:
- Shared package: state encoding constants (IDLE..DONE) and default widths ADDR_W/DATA_W/HOLD_W.
- One natural sub-module: led_hold_timer (loadable down-counter with pause/enable and zero flag).
- The BRAM itself stays outside; the SoC top instantiates it with a preload initial block.

Test Plan:
- Reset mid-HOLD (pointer 7, led 5'h1F) -> led=0, busy=0, step_addr=0 immediately, without waiting for a clock edge.
- Memory 0..3 = 7,6,7,5; last_addr=3, hold_cycles=4, loop_en=0, start -> led 7,6,7,5, each held 6 cycles; done pulses 1 cycle after the last HOLD; busy falls and led stays 5.
- Same setup with loop_en=1 -> after address 3 the sequence shows 7 again at step period 6; done never asserts; stop -> IDLE next edge, led unchanged.
- hold_cycles=0 -> behaves as 1 (period 3). pause=1 asserted for 10 cycles during HOLD -> the step stretches by exactly 10 cycles.
- wr_req held during playback -> wr_ack=0 in every FETCH cycle and 1 otherwise; a write of 3'b001 to address 2 is shown on the next loop pass.
- start and stop in the same cycle from IDLE -> stays IDLE, busy=0; start while busy -> ignored, sequence unaffected; last_addr=30 with DEPTH=21 -> playback ends at address 20.

Source files
------------

// File: rtl/led_pattern_sequencer_pkg.sv
// Purpose : shared state encoding and default widths for the LED pattern sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package led_pattern_sequencer_pkg;

  localparam int LPS_ADDR_W = 5;   // pattern memory address width
  localparam int LPS_DATA_W = 5;   // pattern word / LED width
  localparam int LPS_HOLD_W = 16;  // hold-count width
  localparam int LPS_DEPTH  = 21;  // number of valid pattern words

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Purpose : shared single-port pattern BRAM bus plus the loader write port.
// Latency : mem_rdata valid one cycle after mem_rd_en; wr_ack is same-cycle.
// Backpressure: loader holds wr_req until wr_ack; playback reads win the port.
// Ports   : mem_addr/mem_rd_en/mem_we/mem_wdata/mem_rdata (BRAM side),
//           wr_req/wr_addr/wr_data/wr_ack (loader side).
interface led_pattern_sequencer_if
  import led_pattern_sequencer_pkg::*;
#(
  parameter int ADDR_W = LPS_ADDR_W,
  parameter int DATA_W = LPS_DATA_W
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  // Sequencer side: owns the BRAM port and grants loader writes.
  modport master (
    output mem_addr, mem_rd_en, mem_we, mem_wdata, wr_ack,
    input  mem_rdata, wr_req, wr_addr, wr_data
  );

  // BRAM / loader side.
  modport slave (
    input  mem_addr, mem_rd_en, mem_we, mem_wdata, wr_ack,
    output mem_rdata, wr_req, wr_addr, wr_data
  );

endinterface

// File: rtl/led_hold_timer.sv
// Purpose : loadable down-counter timing how long each pattern stays on the LEDs.
// Latency : load takes effect next edge; zero_o is registered-state derived.
// Backpressure: en_i low (pause) freezes the count; stops at zero.
// Ports   : clk, rst, load_i/load_val_i (load max(val,1)-1), en_i, zero_o.
module led_hold_timer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int HOLD_W = LPS_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [HOLD_W-1:0] load_val_i,
  input  logic              en_i,
  output logic              zero_o
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  // A hold of 0 is treated as 1 so every step shows for at least one tick.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (load_val_i == '0) ? '0 : load_val_i - HOLD_W'(1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Purpose : plays an LED animation from pattern BRAM, holding each word a set number of ticks.
// Latency : led updates 3 cycles after start; step period = max(hold_cycles,1)+2.
// Backpressure: pause freezes the hold count; loader writes wait one cycle behind a fetch.
// Ports   : clk, rst; start_i/stop_i/pause_i/loop_en_i/last_addr_i/hold_cycles_i control;
//           bus (BRAM + loader, master side); led_o, busy_o, done_o, step_addr_o status.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int ADDR_W = LPS_ADDR_W,
  parameter int DATA_W = LPS_DATA_W,
  parameter int DEPTH  = LPS_DEPTH,
  parameter int HOLD_W = LPS_HOLD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    pause_i,
  input  logic                    loop_en_i,
  input  logic [ADDR_W-1:0]       last_addr_i,
  input  logic [HOLD_W-1:0]       hold_cycles_i,
  led_pattern_sequencer_if.master bus,
  output logic [DATA_W-1:0]       led_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ADDR_W-1:0]       step_addr_o
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic              timer_load;
  logic              timer_zero;

  led_hold_timer #(
    .HOLD_W(HOLD_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .load_val_i(hold_cycles_i),
    .en_i      ((state_q == ST_HOLD) && !pause_i),
    .zero_o    (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    led_d      = led_q;
    step_d     = step_q;
    timer_load = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          state_d = ST_FETCH;
          ptr_d   = '0;
          // Clamp so the pointer can never walk past the valid words.
          last_d  = (last_addr_i > MAX_ADDR) ? MAX_ADDR : last_addr_i;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        led_d      = bus.mem_rdata;
        step_d     = ptr_q;
        timer_load = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (timer_zero && !pause_i) begin
          if (ptr_q == last_q) begin
            if (loop_en_i) begin
              ptr_d   = '0;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything: the shown pattern stays, no done pulse.
    if (stop_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      ptr_d   = '0;
      led_d   = led_q;
      step_d  = step_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      led_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  // The playback read owns the port only in FETCH; every other cycle is free
  // for the loader, so a pending write waits at most one cycle.
  assign bus.wr_ack    = bus.wr_req && (state_q != ST_FETCH) && !rst;
  assign bus.mem_we    = bus.wr_ack;
  assign bus.mem_rd_en = (state_q == ST_FETCH);
  assign bus.mem_addr  = bus.wr_ack ? bus.wr_addr : ptr_q;
  assign bus.mem_wdata = bus.wr_data;

  assign led_o       = led_q;
  assign step_addr_o = step_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Purpose : directed self-checking bench for led_pattern_sequencer with a BRAM model.
// Latency : n/a.
// Backpressure: n/a.
module tb_led_pattern_sequencer;
  import led_pattern_sequencer_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 5;
  localparam int HW    = 16;
  localparam int DEPTH = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, stop_i, pause_i, loop_en_i;
  logic [AW-1:0] last_addr_i;
  logic [HW-1:0] hold_cycles_i;
  logic [DW-1:0] led_o;
  logic          busy_o, done_o;
  logic [AW-1:0] step_addr_o;

  led_pattern_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  led_pattern_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .HOLD_W(HW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .pause_i      (pause_i),
    .loop_en_i    (loop_en_i),
    .last_addr_i  (last_addr_i),
    .hold_cycles_i(hold_cycles_i),
    .bus          (bus),
    .led_o        (led_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .step_addr_o  (step_addr_o)
  );

  always #5 clk = ~clk;

  // Single-port BRAM model, one-cycle read latency.
  logic [DW-1:0] mem [0:31];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-negedge trace of one playback run; index k = k-th negedge after start.
  logic [DW-1:0] led_tr  [0:79];
  logic [AW-1:0] step_tr [0:79];
  logic          done_tr [0:79];
  logic          busy_tr [0:79];
  logic          ack_tr  [0:79];
  int            done_cnt;
  int            stop_at, pause_from, pause_to, wr_from, restart_at;

  task automatic clear_cfg();
    stop_at    = -1;
    pause_from = -1;
    pause_to   = -1;
    wr_from    = -1;
    restart_at = -1;
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_req  = 1'b0;
  endtask

  task automatic play(input int n);
    @(negedge clk);
    start_i  = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      stop_i  = 1'b0;
      led_tr[k]  = led_o;
      step_tr[k] = step_addr_o;
      done_tr[k] = done_o;
      busy_tr[k] = busy_o;
      ack_tr[k]  = bus.wr_ack;
      if (done_o) done_cnt++;
      if (k == stop_at)    stop_i = 1'b1;
      if (k == pause_from) pause_i = 1'b1;
      if (k == pause_to)   pause_i = 1'b0;
      if (k == wr_from)    bus.wr_req = 1'b1;
      if (k == restart_at) start_i = 1'b1;
    end
    @(negedge clk);
    start_i    = 1'b0;
    stop_i     = 1'b1;
    pause_i    = 1'b0;
    bus.wr_req = 1'b0;
    @(negedge clk);
    stop_i = 1'b0;
  endtask

  initial begin
    logic found;
    rst           = 1'b1;
    start_i       = 1'b0;
    stop_i        = 1'b0;
    pause_i       = 1'b0;
    loop_en_i     = 1'b0;
    last_addr_i   = '0;
    hold_cycles_i = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    clear_cfg();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_led", led_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_step", step_addr_o, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_we", bus.mem_we, 0);
    rst = 1'b0;

    // Preload: word i = i, except word 7 = 1F.
    for (int i = 0; i < DEPTH; i++) load(i, (i == 7) ? 5'h1F : DW'(i));

    // Asynchronous reset while holding step 7.
    last_addr_i   = 5'd20;
    hold_cycles_i = 16'd20;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (busy_o && step_addr_o == 5'd7) found = 1'b1;
    end
    chk("t1_reach_step7", found, 1);
    chk("t1_led_1f", led_o, 5'h1F);
    #1 rst = 1'b1;
    #1;
    chk("t1_arst_led", led_o, 0);
    chk("t1_arst_busy", busy_o, 0);
    chk("t1_arst_step", step_addr_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot playback 7,6,7,5 with hold 4 (period 6).
    load(0, 5'd7); load(1, 5'd6); load(2, 5'd7); load(3, 5'd5);
    last_addr_i   = 5'd3;
    hold_cycles_i = 16'd4;
    loop_en_i     = 1'b0;
    clear_cfg();
    play(27);
    chk("t2_led_k2", led_tr[2], 0);
    chk("t2_led_k3", led_tr[3], 7);
    chk("t2_led_k8", led_tr[8], 7);
    chk("t2_led_k9", led_tr[9], 6);
    chk("t2_led_k15", led_tr[15], 7);
    chk("t2_led_k21", led_tr[21], 5);
    chk("t2_step_k21", step_tr[21], 3);
    chk("t2_done_k24", done_tr[24], 0);
    chk("t2_done_k25", done_tr[25], 1);
    chk("t2_busy_k25", busy_tr[25], 1);
    chk("t2_busy_k26", busy_tr[26], 0);
    chk("t2_led_k26", led_tr[26], 5);
    chk("t2_done_cnt", done_cnt, 1);

    // Looping playback, then stop in HOLD.
    loop_en_i = 1'b1;
    clear_cfg();
    stop_at = 40;
    play(42);
    chk("t3_led_k21", led_tr[21], 5);
    chk("t3_led_k26", led_tr[26], 5);
    chk("t3_led_k27", led_tr[27], 7);
    chk("t3_step_k27", step_tr[27], 0);
    chk("t3_led_k33", led_tr[33], 6);
    chk("t3_busy_k40", busy_tr[40], 1);
    chk("t3_busy_k41", busy_tr[41], 0);
    chk("t3_led_k41", led_tr[41], 7);
    chk("t3_led_k42", led_tr[42], 7);
    chk("t3_done_cnt", done_cnt, 0);

    // hold 0 acts as 1 (period 3); 10-cycle pause in step 2; start while busy ignored.
    loop_en_i     = 1'b0;
    hold_cycles_i = 16'd0;
    clear_cfg();
    pause_from = 9;
    pause_to   = 19;
    restart_at = 5;
    play(25);
    chk("t4_led_k3", led_tr[3], 7);
    chk("t4_led_k4", led_tr[4], 7);
    chk("t4_led_k6", led_tr[6], 6);
    chk("t4_led_k9", led_tr[9], 7);
    chk("t4_busy_k19", busy_tr[19], 1);
    chk("t4_led_k21", led_tr[21], 7);
    chk("t4_led_k22", led_tr[22], 5);
    chk("t4_done_k23", done_tr[23], 1);
    chk("t4_busy_k24", busy_tr[24], 0);
    chk("t4_done_cnt", done_cnt, 1);

    // Loader write of 1 to address 2 during looping playback.
    loop_en_i     = 1'b1;
    hold_cycles_i = 16'd4;
    bus.wr_addr   = 5'd2;
    bus.wr_data   = 5'b00001;
    clear_cfg();
    wr_from = 16;
    stop_at = 40;
    play(41);
    for (int k = 17; k <= 40; k++) begin
      chk($sformatf("t5_ack_k%0d", k), ack_tr[k], ((k - 1) % 6) != 0);
    end
    chk("t5_led_k20", led_tr[20], 7);
    chk("t5_led_k21", led_tr[21], 5);
    chk("t5_led_k39", led_tr[39], 1);
    chk("t5_step_k39", step_tr[39], 2);

    // start and stop together from IDLE.
    @(negedge clk);
    start_i = 1'b1;
    stop_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk("t6_startstop_busy", busy_o, 0);
    @(negedge clk);
    chk("t6_startstop_busy2", busy_o, 0);

    // last_addr 30 clamps to 20.
    loop_en_i     = 1'b0;
    hold_cycles_i = 16'd0;
    last_addr_i   = 5'd30;
    clear_cfg();
    play(66);
    chk("t7_step_k63", step_tr[63], 20);
    chk("t7_led_k63", led_tr[63], 5'h14);
    chk("t7_done_k64", done_tr[64], 1);
    chk("t7_busy_k65", busy_tr[65], 0);
    chk("t7_step_k66", step_tr[66], 20);
    chk("t7_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
